csr_evt_bank: RTL and testbench
===============================

// Module: csr_evt_bank
// PURPOSE
//  Parametrised next-generation accelerator CSR bank, driven by the host CSR bus (UART bridge or AXI-lite shim).
//  Provides a generic config register file and start/abort pulses with a one-deep queued start.
//  Adds NUM_EVT sticky event channels with per-channel saturating counters, a masked level IRQ,
//  and registered reads with an error flag.
// PARAMETERS
//  ADDR_W     8             byte address width; map fits 256 B
//  NUM_CFG    16            32-bit RW config regs at 0x40+4*i (1..48)
//  NUM_EVT    8             event channels (1..8)
//  CNT_W      16            event counter width (1..32), saturating
//  GUARD_MASK {NUM_CFG{1'b0}} bit i=1: CFG[i]==0 blocks start
// PORTS
//  clk         in   1               clock
//  rst         in   1               synchronous active-high reset
//  csr_wen     in   1               write strobe
//  csr_ren     in   1               read strobe
//  csr_addr    in   ADDR_W          byte address; bits [1:0] ignored
//  csr_wdata   in   32              write data
//  csr_rdata   out  32              read data, valid with csr_rvalid
//  csr_rvalid  out  1               1-cycle pulse, cycle after csr_ren
//  csr_rerr    out  1               with csr_rvalid: unmapped address
//  core_busy   in   1               core running
//  evt_pulse   in   NUM_EVT         event pulses; each high cycle counts once
//  start_pulse out  1               1-cycle start to core FSM
//  abort_pulse out  1               1-cycle abort to core FSM
//  start_pend  out  1               queued start waiting
//  irq         out  1               level interrupt, registered
//  cfg_flat    out  32*NUM_CFG      CFG[i] at bits [32*i+31:32*i]
// BEHAVIOUR
//  Map:
//   0x00 CTRL      [0] start W1P; [1] abort W1P; [2] irq_en RW; [3] queue_en RW; reads {irq_en,queue_en}, W1P bits read 0
//   0x04 STATUS    [0] core_busy RO; [1] start_pend RO; [8] err_start R/W1C
//   0x08 EVT_STAT  [NUM_EVT-1:0] sticky, R/W1C
//   0x0C EVT_MASK  [NUM_EVT-1:0] RW
//   0x20+4*i EVT_CNT[i] (i<NUM_EVT) RO zero-extended; any write clears it
//   0x40+4*i CFG[i] RW
//  Unmapped read: rdata=32'hDEAD_BEEF, rerr=1. Unmapped write: ignored.
//  Reset: all outputs, regs, counters, status 0; rdata 0; FSM IDLE.
//  Read: csr_ren in cycle T samples pre-write state of T; rdata/rvalid/rerr registered at T+1.
//  Write to a read-only field: ignored.
//  Start FSM (IDLE, PEND):
//   - guard_ok = no CFG[i]==0 where GUARD_MASK[i]=1
//   - Start write in T, IDLE, core_busy=0, guard_ok: start_pulse at T+1.
//   - Start write in T, IDLE, core_busy=1, queue_en=1, guard_ok: go to PEND, start_pend=1 from T+1.
//   - PEND and core_busy==0 in cycle T: start_pulse at T+1, return to IDLE, start_pend=0 at T+1.
//   - Start write blocked (guard fail; busy with queue_en=0; already PEND): set err_start, no pulse, FSM unchanged.
//   - Abort write in T: abort_pulse at T+1. Any PEND is cancelled, with no start_pulse.
//   - Start and abort in the same write: abort wins; no start, no err_start.
//  Events:
//   - evt_pulse[i] sets EVT_STAT[i] and increments EVT_CNT[i]; counter saturates at 2^CNT_W-1, never wraps.
//   - Set and W1C in the same cycle: set wins, bit stays 1.
//   - Count and clear in the same cycle: counter becomes 1.
//   - err_start set and W1C in the same cycle: set wins.
//  irq at T+1 = irq_en & |(EVT_STAT & EVT_MASK) at T; stays high until cleared or masked.
//  Reset mid-operation: next cycle all state is at reset values; a pending start is dropped.
// TESTING
//  1 reset; read every mapped addr -> CTRL/STATUS/EVT/CNT/CFG 0, rvalid 1 cycle later; read 0xFC -> DEADBEEF, rerr=1
//  2 GUARD_MASK=1, CFG0=0, start -> no pulse, STATUS=0x100; W1C 0x100 -> STATUS 0; CFG0=4, start -> 1 start_pulse
//  3 queue_en=1, busy=1, start -> start_pend=1; 2nd start -> err_start; busy falls at T -> start_pulse at T+1, start_pend=0
//  4 queue_en=1, busy=1, start then abort -> abort_pulse, start_pend=0, busy falls -> no start_pulse
//  5 CNT_W=2: evt_pulse[3] held 5 cycles -> EVT_CNT3=3 (saturated); W1C 0x8 in same cycle as a pulse -> EVT_STAT[3] stays 1
//  6 mask=0x8, irq_en=1, evt_pulse[3] at T -> irq at T+2; W1C 0x8 (no pulse) -> irq low next cycle

Source files
------------

// File: rtl/csr_evt_bank_if.sv
// Host CSR bus shared by the UART bridge and the AXI-lite shim.
// Reads are strobed, and the response comes back registered one cycle later.
interface csr_evt_bank_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              csr_wen;
    logic              csr_ren;
    logic [ADDR_W-1:0] csr_addr;
    logic [31:0]       csr_wdata;
    logic [31:0]       csr_rdata;
    logic              csr_rvalid;
    logic              csr_rerr;

    modport master (
        output csr_wen, csr_ren, csr_addr, csr_wdata,
        input  csr_rdata, csr_rvalid, csr_rerr
    );

    modport slave (
        input  csr_wen, csr_ren, csr_addr, csr_wdata,
        output csr_rdata, csr_rvalid, csr_rerr
    );
endinterface

// File: rtl/csr_evt_bank.sv
// Accelerator CSR bank: config registers, start/abort control with a one-deep queued start,
// sticky event channels with saturating counters, a masked level IRQ and registered reads.
module csr_evt_bank #(
    parameter int unsigned        ADDR_W     = 8,
    parameter int unsigned        NUM_CFG    = 16,
    parameter int unsigned        NUM_EVT    = 8,
    parameter int unsigned        CNT_W      = 16,
    parameter logic [NUM_CFG-1:0] GUARD_MASK = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    csr_evt_bank_if.slave          csr,
    input  logic                   core_busy,
    input  logic [NUM_EVT-1:0]     evt_pulse,
    output logic                   start_pulse,
    output logic                   abort_pulse,
    output logic                   start_pend,
    output logic                   irq,
    output logic [32*NUM_CFG-1:0]  cfg_flat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_irq_en, r_queue_en, r_err_start;
    logic [NUM_EVT-1:0] r_evt_stat, r_evt_mask;
    logic [CNT_W-1:0]   r_cnt [NUM_EVT];
    logic [31:0]        r_cfg [NUM_CFG];
    logic [31:0]        r_rdata;
    logic               r_rvalid, r_rerr, r_start_pulse, r_abort_pulse, r_irq;

    logic [31:0]        w_idx;
    logic               w_wr_ctrl, w_wr_stat, w_wr_evt, w_wr_mask;
    logic [NUM_EVT-1:0] w_cnt_clr;
    logic [NUM_CFG-1:0] w_cfg_wr;
    logic               w_start_req, w_abort_req, w_guard_ok, w_start_nxt, w_err_set;
    logic [31:0]        w_rd_data;
    logic               w_rd_err;

    // Decode on the word index; the byte-lane bits [1:0] fall away in the shift.
    always_comb begin
        w_idx     = 32'(csr.csr_addr[ADDR_W-1:0]) >> 2;
        w_wr_ctrl = csr.csr_wen && (w_idx == 32'd0);
        w_wr_stat = csr.csr_wen && (w_idx == 32'd1);
        w_wr_evt  = csr.csr_wen && (w_idx == 32'd2);
        w_wr_mask = csr.csr_wen && (w_idx == 32'd3);
        w_cnt_clr = '0;
        w_cfg_wr  = '0;
        for (int unsigned i = 0; i < NUM_EVT; i++)
            w_cnt_clr[i] = csr.csr_wen && (w_idx == 32'd8 + i);
        for (int unsigned i = 0; i < NUM_CFG; i++)
            w_cfg_wr[i] = csr.csr_wen && (w_idx == 32'd16 + i);
        w_abort_req = w_wr_ctrl && csr.csr_wdata[1];
        w_start_req = w_wr_ctrl && csr.csr_wdata[0] && !csr.csr_wdata[1];
    end

    always_comb begin
        w_rd_data = 32'hDEAD_BEEF;
        w_rd_err  = 1'b1;
        if (w_idx == 32'd0) begin
            w_rd_data = {28'd0, r_queue_en, r_irq_en, 2'b00};
            w_rd_err  = 1'b0;
        end
        if (w_idx == 32'd1) begin
            w_rd_data = {23'd0, r_err_start, 6'd0, (r_state == ST_PEND), core_busy};
            w_rd_err  = 1'b0;
        end
        if (w_idx == 32'd2) begin
            w_rd_data = 32'(r_evt_stat);
            w_rd_err  = 1'b0;
        end
        if (w_idx == 32'd3) begin
            w_rd_data = 32'(r_evt_mask);
            w_rd_err  = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_EVT; i++) begin
            if (w_idx == 32'd8 + i) begin
                w_rd_data = 32'(r_cnt[i]);
                w_rd_err  = 1'b0;
            end
        end
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
            if (w_idx == 32'd16 + i) begin
                w_rd_data = r_cfg[i];
                w_rd_err  = 1'b0;
            end
        end
    end

    always_comb begin
        w_guard_ok = 1'b1;
        for (int unsigned i = 0; i < NUM_CFG; i++)
            if (GUARD_MASK[i] && (r_cfg[i] == '0)) w_guard_ok = 1'b0;
    end

    // Abort overrides everything. A start arriving while PEND is rejected even if the queued one launches.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_err_set   = 1'b0;
        if (w_abort_req) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_req) begin
                        if (!w_guard_ok || (core_busy && !r_queue_en)) w_err_set = 1'b1;
                        else if (core_busy)                            w_state_nxt = ST_PEND;
                        else                                           w_start_nxt = 1'b1;
                    end
                end
                ST_PEND: begin
                    w_err_set = w_start_req;
                    if (!core_busy) begin
                        w_start_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_irq_en      <= 1'b0;
            r_queue_en    <= 1'b0;
            r_err_start   <= 1'b0;
            r_evt_stat    <= '0;
            r_evt_mask    <= '0;
            r_rdata       <= '0;
            r_rvalid      <= 1'b0;
            r_rerr        <= 1'b0;
            r_start_pulse <= 1'b0;
            r_abort_pulse <= 1'b0;
            r_irq         <= 1'b0;
            for (int unsigned i = 0; i < NUM_EVT; i++) r_cnt[i] <= '0;
            for (int unsigned i = 0; i < NUM_CFG; i++) r_cfg[i] <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_start_pulse <= w_start_nxt;
            r_abort_pulse <= w_abort_req;
            r_irq         <= r_irq_en && |(r_evt_stat & r_evt_mask);
            r_rvalid      <= csr.csr_ren;
            r_rerr        <= csr.csr_ren && w_rd_err;
            if (csr.csr_ren) r_rdata <= w_rd_data;
            if (w_wr_ctrl) begin
                r_irq_en   <= csr.csr_wdata[2];
                r_queue_en <= csr.csr_wdata[3];
            end
            if (w_wr_mask) r_evt_mask <= csr.csr_wdata[NUM_EVT-1:0];
            r_err_start <= w_err_set || (r_err_start && !(w_wr_stat && csr.csr_wdata[8]));
            r_evt_stat  <= (r_evt_stat & ~({NUM_EVT{w_wr_evt}} & csr.csr_wdata[NUM_EVT-1:0])) | evt_pulse;
            for (int unsigned i = 0; i < NUM_EVT; i++) begin
                if (w_cnt_clr[i])
                    r_cnt[i] <= CNT_W'(evt_pulse[i]);
                else if (evt_pulse[i] && (r_cnt[i] != CNT_MAX))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
            for (int unsigned i = 0; i < NUM_CFG; i++)
                if (w_cfg_wr[i]) r_cfg[i] <= csr.csr_wdata;
        end
    end

    always_comb begin
        cfg_flat = '0;
        for (int unsigned i = 0; i < NUM_CFG; i++) cfg_flat[32*i +: 32] = r_cfg[i];
    end

    assign csr.csr_rdata  = r_rdata;
    assign csr.csr_rvalid = r_rvalid;
    assign csr.csr_rerr   = r_rerr;
    assign start_pulse    = r_start_pulse;
    assign abort_pulse    = r_abort_pulse;
    assign start_pend     = (r_state == ST_PEND);
    assign irq            = r_irq;
endmodule

// File: tb/tb_csr_evt_bank.sv
// Bench for csr_evt_bank: a register-level reference model is updated on every clock edge
// and compared each cycle, followed by directed scenarios and a randomized phase.
module tb_csr_evt_bank;
    localparam int unsigned NCFG  = 4;
    localparam int unsigned NEVT  = 8;
    localparam int unsigned CW    = 2;
    localparam int unsigned CMAX  = (1 << CW) - 1;
    localparam logic [NCFG-1:0] GMASK = 4'b0001;

    logic clk = 1'b0;
    logic rst;
    logic core_busy;
    logic [NEVT-1:0] evt_pulse;
    logic start_pulse, abort_pulse, start_pend, irq;
    logic [32*NCFG-1:0] cfg_flat;

    csr_evt_bank_if #(.ADDR_W(8)) bus ();

    csr_evt_bank #(
        .ADDR_W(8), .NUM_CFG(NCFG), .NUM_EVT(NEVT), .CNT_W(CW), .GUARD_MASK(GMASK)
    ) dut (
        .clk(clk), .rst(rst), .csr(bus.slave), .core_busy(core_busy), .evt_pulse(evt_pulse),
        .start_pulse(start_pulse), .abort_pulse(abort_pulse), .start_pend(start_pend),
        .irq(irq), .cfg_flat(cfg_flat)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        else n_pass++;
    endtask

    // Reference model: architectural register state.
    bit          m_ready = 0;
    bit          m_irq_en, m_queue_en, m_err, m_pend;
    logic [7:0]  m_stat, m_mask;
    int unsigned m_cnt [NEVT];
    logic [31:0] m_cfg [NCFG];
    logic [31:0] exp_rdata;
    bit          exp_rvalid, exp_rerr, exp_sp, exp_ap, exp_pend, exp_irq;

    function automatic void mread(input int unsigned ai, output logic [31:0] d, output bit err);
        err = 0;
        if (ai == 0)                         d = (32'(m_queue_en) << 3) | (32'(m_irq_en) << 2);
        else if (ai == 1)                    d = (32'(m_err) << 8) | (32'(m_pend) << 1) | 32'(core_busy);
        else if (ai == 2)                    d = 32'(m_stat);
        else if (ai == 3)                    d = 32'(m_mask);
        else if (ai >= 8 && ai < 8 + NEVT)   d = m_cnt[ai-8];
        else if (ai >= 16 && ai < 16 + NCFG) d = m_cfg[ai-16];
        else begin
            d   = 32'hDEADBEEF;
            err = 1;
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] rd_d;
        bit rd_e, was_pend, st_req, ab_req, g_ok, set_err, wen;
        int unsigned ai;
        logic [31:0] wd;
        if (rst === 1'b1) begin
            m_irq_en = 0; m_queue_en = 0; m_err = 0; m_pend = 0;
            m_stat = '0; m_mask = '0;
            for (int i = 0; i < NEVT; i++) m_cnt[i] = 0;
            for (int i = 0; i < NCFG; i++) m_cfg[i] = '0;
            exp_rdata = '0; exp_rvalid = 0; exp_rerr = 0;
            exp_sp = 0; exp_ap = 0; exp_pend = 0; exp_irq = 0;
            m_ready = 1;
        end else if (m_ready) begin
            ai  = 32'(bus.csr_addr) >> 2;
            wen = bus.csr_wen;
            wd  = bus.csr_wdata;
            exp_rvalid = bus.csr_ren;
            if (bus.csr_ren) begin
                mread(ai, rd_d, rd_e);
                exp_rdata = rd_d;
                exp_rerr  = rd_e;
            end
            exp_irq = m_irq_en && ((m_stat & m_mask) != 0);
            g_ok = 1;
            for (int i = 0; i < NCFG; i++) if (GMASK[i] && m_cfg[i] == 0) g_ok = 0;
            ab_req   = wen && ai == 0 && wd[1];
            st_req   = wen && ai == 0 && wd[0] && !ab_req;
            was_pend = m_pend;
            exp_sp   = 0;
            exp_ap   = ab_req;
            set_err  = 0;
            if (ab_req) m_pend = 0;
            else begin
                if (was_pend && !core_busy) begin
                    exp_sp = 1;
                    m_pend = 0;
                end
                if (st_req) begin
                    if (!g_ok || was_pend || (core_busy && !m_queue_en)) set_err = 1;
                    else if (core_busy) m_pend = 1;
                    else exp_sp = 1;
                end
            end
            m_err = set_err || (m_err && !(wen && ai == 1 && wd[8]));
            if (wen && ai == 2) m_stat = m_stat & ~wd[7:0];
            m_stat = m_stat | evt_pulse;
            for (int i = 0; i < NEVT; i++) begin
                if (wen && ai == 8 + i) m_cnt[i] = evt_pulse[i] ? 1 : 0;
                else if (evt_pulse[i] && m_cnt[i] < CMAX) m_cnt[i]++;
            end
            if (wen && ai == 0) begin
                m_irq_en   = wd[2];
                m_queue_en = wd[3];
            end
            if (wen && ai == 3) m_mask = wd[7:0];
            for (int i = 0; i < NCFG; i++) if (wen && ai == 16 + i) m_cfg[i] = wd;
            exp_pend = m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("start_pulse", 32'(start_pulse), 32'(exp_sp));
            chk("abort_pulse", 32'(abort_pulse), 32'(exp_ap));
            chk("start_pend", 32'(start_pend), 32'(exp_pend));
            chk("irq", 32'(irq), 32'(exp_irq));
            chk("rvalid", 32'(bus.csr_rvalid), 32'(exp_rvalid));
            if (exp_rvalid) begin
                chk("rdata", bus.csr_rdata, exp_rdata);
                chk("rerr", 32'(bus.csr_rerr), 32'(exp_rerr));
            end
            for (int i = 0; i < NCFG; i++) chk("cfg_flat", cfg_flat[32*i +: 32], m_cfg[i]);
        end
    end

    bit         g_busy = 0;
    bit         g_rst  = 0;
    logic [7:0] g_evt  = '0;

    task automatic step(input bit wen, input bit ren, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.csr_wen = wen; bus.csr_ren = ren; bus.csr_addr = a; bus.csr_wdata = d;
        core_busy = g_busy; evt_pulse = g_evt; rst = g_rst;
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1, 0, a, d);
    endtask

    task automatic rdchk(input logic [7:0] a, input logic [31:0] lit, input string nm);
        step(0, 1, a, 32'h0);
        idle();
        chk(nm, bus.csr_rdata, lit);
    endtask

    logic [7:0]  ra;
    logic [31:0] rd;
    int unsigned op;

    initial begin
        rst = 1'b1; core_busy = 1'b0; evt_pulse = '0;
        bus.csr_wen = 1'b0; bus.csr_ren = 1'b0; bus.csr_addr = '0; bus.csr_wdata = '0;

        // Reset state and read-back of every mapped address.
        g_rst = 1; idle(); idle();
        g_rst = 0; idle();
        chk("rst_rdata", bus.csr_rdata, 32'h0);
        chk("rst_rvalid", 32'(bus.csr_rvalid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_cfg_flat", cfg_flat[31:0], 32'h0);
        for (int i = 0; i < 4; i++) rdchk(8'(4 * i), 32'h0, "rst_csr");
        for (int i = 0; i < NEVT; i++) rdchk(8'(32 + 4 * i), 32'h0, "rst_cnt");
        for (int i = 0; i < NCFG; i++) rdchk(8'(64 + 4 * i), 32'h0, "rst_cfg");
        rdchk(8'hFC, 32'hDEADBEEF, "unmapped_rdata");
        chk("unmapped_rerr", 32'(bus.csr_rerr), 32'h1);

        // Guard: CFG0 == 0 blocks start.
        wr(8'h00, 32'h1); idle();
        chk("guard_no_pulse", 32'(start_pulse), 32'h0);
        rdchk(8'h04, 32'h100, "guard_err_status");
        wr(8'h04, 32'h100);
        rdchk(8'h04, 32'h0, "err_w1c");
        wr(8'h40, 32'h4);
        wr(8'h00, 32'h1); idle();
        chk("guard_ok_pulse", 32'(start_pulse), 32'h1);
        idle();
        chk("pulse_one_cycle", 32'(start_pulse), 32'h0);

        // Queued start while busy.
        wr(8'h00, 32'h8);
        g_busy = 1;
        wr(8'h00, 32'h9); idle();
        chk("queue_pend", 32'(start_pend), 32'h1);
        wr(8'h00, 32'h9); idle();
        rdchk(8'h04, 32'h103, "second_start_err");
        g_busy = 0; idle(); idle();
        chk("pend_launch", 32'(start_pulse), 32'h1);
        chk("pend_cleared", 32'(start_pend), 32'h0);
        wr(8'h04, 32'h100);

        // Abort cancels a pending start.
        g_busy = 1;
        wr(8'h00, 32'h9); idle();
        wr(8'h00, 32'hA); idle();
        chk("abort_pulse", 32'(abort_pulse), 32'h1);
        chk("abort_cancel", 32'(start_pend), 32'h0);
        g_busy = 0; idle(); idle();
        chk("abort_no_start", 32'(start_pulse), 32'h0);

        // Reset drops a pending start.
        g_busy = 1;
        wr(8'h00, 32'h9); idle();
        g_rst = 1; idle();
        g_rst = 0; g_busy = 0; idle();
        chk("rst_drop_pend", 32'(start_pend), 32'h0);
        idle();
        chk("rst_no_start", 32'(start_pulse), 32'h0);

        // Counter saturation and set-beats-clear.
        g_evt = 8'h08;
        repeat (5) idle();
        g_evt = 8'h00; idle();
        chk("model_cnt3", m_cnt[3], 32'd3);
        rdchk(8'h2C, 32'h3, "cnt_saturate");
        g_evt = 8'h08; wr(8'h08, 32'h8);
        g_evt = 8'h00; idle();
        rdchk(8'h08, 32'h8, "stat_set_wins");

        // IRQ latency and clear.
        wr(8'h0C, 32'h8); wr(8'h00, 32'h4); wr(8'h08, 32'hFF);
        idle(); idle();
        chk("irq_idle_low", 32'(irq), 32'h0);
        g_evt = 8'h08; idle();
        g_evt = 8'h00; idle();
        chk("irq_t1_low", 32'(irq), 32'h0);
        idle();
        chk("irq_t2_high", 32'(irq), 32'h1);
        wr(8'h08, 32'h8); idle(); idle();
        chk("irq_cleared", 32'(irq), 32'h0);

        // Randomized traffic.
        wr(8'h40, 32'h1);
        for (int n = 0; n < 3000; n++) begin
            g_rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 9) == 0) g_busy = !g_busy;
            g_evt = 8'($urandom) & 8'($urandom) & 8'($urandom);
            case ($urandom_range(0, 3))
                0:       ra = 8'($urandom_range(0, 3) * 4);
                1:       ra = 8'(32 + $urandom_range(0, 8) * 4);
                2:       ra = 8'(64 + $urandom_range(0, 5) * 4);
                default: ra = 8'($urandom);
            endcase
            ra[1:0] = 2'($urandom);
            if (ra[7:2] == 6'd0)      rd = 32'($urandom_range(0, 15));
            else if (ra[7:2] < 6'd8)  rd = $urandom & 32'h1FF;
            else if ($urandom_range(0, 3) == 0) rd = 32'h0;
            else                      rd = $urandom;
            op = $urandom_range(0, 9);
            if (op < 4)      idle();
            else if (op < 7) step(0, 1, ra, 32'h0);
            else if (op < 9) wr(ra, rd);
            else             step(1, 1, ra, rd);
        end
        g_rst = 0; g_evt = '0; idle(); idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
